// File: rtl/dmem_alu.sv
// rtl/dmem_alu.sv - RV32I execute-stage ALU with single-port data-memory request FSM
//
// Purpose:
//   Computes the ALU result, load/store addresses and branch decision from
//   decoded instruction fields, and drives one data-bus transaction per
//   load/store instruction. Load data is returned on data_cpu_o.
//
// Optional feature (macro DMEM_LOAD_EXTEND_EN):
//   When defined, load data is sign/zero-extended from lane 0 by funct3
//   (LB/LH/LBU/LHU/LW) before it is captured into data_cpu_o.
//   When undefined, data_bus_i is captured unmodified.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   MemToReg         result select: 1 = data_cpu_o, 0 = ALU output
//   ALU_source       operand B select: 0 = reg2, 1 = immediate
//   opcode/funct3/funct7  decoded RV32I instruction fields
//   reg1, reg2       rs1 / rs2 values (reg2 is also store data)
//   immediate        sign-extended immediate
//   data_bus_i       memory read data
//   data_good        memory transaction complete
//   read_address     combinational load address (0 when not a load)
//   write_address    combinational store address (0 when not a store)
//   result           combinational writeback value
//   branch           combinational branch-taken flag
//   data_read        registered read strobe
//   data_write       registered write strobe
//   data_adr_o       registered memory address
//   data_bus_o       registered memory write data
//   data_cpu_o       registered data of the last completed load

module dmem_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToReg,
  input  logic        ALU_source,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] immediate,
  input  logic [31:0] data_bus_i,
  input  logic        data_good,
  output logic [31:0] read_address,
  output logic [31:0] write_address,
  output logic [31:0] result,
  output logic        branch,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_adr_o,
  output logic [31:0] data_bus_o,
  output logic [31:0] data_cpu_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        data_read_q, data_read_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_adr_q, data_adr_d;
  logic [31:0] data_bus_q, data_bus_d;
  logic [31:0] data_cpu_q, data_cpu_d;

  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] alu_out;
  logic [31:0] load_data;
  logic [4:0]  shamt;
  logic        is_load;
  logic        is_store;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign op_b     = ALU_source ? immediate : reg2;
  assign sum      = reg1 + op_b;
  assign shamt    = op_b[4:0];

  // ALU
  always_comb begin
    alu_out = 32'd0;
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        // SUB exists only in R-type; ADDI's upper bits are immediate, not funct7.
        3'b000: alu_out = (opcode == OP_R && funct7 == 7'b0100000) ? (reg1 - op_b) : sum;
        3'b001: alu_out = reg1 << shamt;
        3'b010: alu_out = {31'd0, ($signed(reg1) < $signed(op_b))};
        3'b011: alu_out = {31'd0, (reg1 < op_b)};
        3'b100: alu_out = reg1 ^ op_b;
        3'b101: alu_out = funct7[5] ? 32'($signed(reg1) >>> shamt) : (reg1 >> shamt);
        3'b110: alu_out = reg1 | op_b;
        default: alu_out = reg1 & op_b;
      endcase
    end else if (is_load || is_store) begin
      alu_out = sum;
    end
  end

  // Branch decision always compares rs1 against rs2, independent of ALU_source.
  always_comb begin
    branch = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'b000:  branch = (reg1 == reg2);
        3'b001:  branch = (reg1 != reg2);
        3'b100:  branch = ($signed(reg1) <  $signed(reg2));
        3'b101:  branch = ($signed(reg1) >= $signed(reg2));
        3'b110:  branch = (reg1 <  reg2);
        3'b111:  branch = (reg1 >= reg2);
        default: branch = 1'b0;
      endcase
    end
  end

  assign read_address  = is_load  ? sum : 32'd0;
  assign write_address = is_store ? sum : 32'd0;
  assign result        = MemToReg ? data_cpu_q : alu_out;

  // Load data formatting at capture time
  always_comb begin
    load_data = data_bus_i;
`ifdef DMEM_LOAD_EXTEND_EN
    case (funct3)
      3'b000:  load_data = {{24{data_bus_i[7]}}, data_bus_i[7:0]};
      3'b001:  load_data = {{16{data_bus_i[15]}}, data_bus_i[15:0]};
      3'b100:  load_data = {24'd0, data_bus_i[7:0]};
      3'b101:  load_data = {16'd0, data_bus_i[15:0]};
      default: load_data = data_bus_i;
    endcase
`endif
  end

  // FSM next state and registered outputs
  always_comb begin
    state_d      = state_q;
    data_read_d  = data_read_q;
    data_write_d = data_write_q;
    data_adr_d   = data_adr_q;
    data_bus_d   = data_bus_q;
    data_cpu_d   = data_cpu_q;
    case (state_q)
      IDLE: begin
        if (is_load) begin
          state_d     = READ;
          data_read_d = 1'b1;
          data_adr_d  = read_address;
        end else if (is_store) begin
          state_d      = WRITE;
          data_write_d = 1'b1;
          data_adr_d   = write_address;
          data_bus_d   = reg2;
        end else begin
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
          data_adr_d   = 32'd0;
          data_bus_d   = 32'd0;
        end
      end
      READ: begin
        if (data_good) begin
          state_d     = DONE;
          data_cpu_d  = load_data;
          data_read_d = 1'b0;
          data_adr_d  = 32'd0;
        end
      end
      WRITE: begin
        if (data_good) begin
          state_d      = DONE;
          data_write_d = 1'b0;
          data_adr_d   = 32'd0;
          data_bus_d   = 32'd0;
        end
      end
      default: begin
        // Wait for the instruction to leave so it issues only one transaction.
        data_read_d  = 1'b0;
        data_write_d = 1'b0;
        if (!is_load && !is_store) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_read_q  <= 1'b0;
      data_write_q <= 1'b0;
      data_adr_q   <= 32'd0;
      data_bus_q   <= 32'd0;
      data_cpu_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      data_read_q  <= data_read_d;
      data_write_q <= data_write_d;
      data_adr_q   <= data_adr_d;
      data_bus_q   <= data_bus_d;
      data_cpu_q   <= data_cpu_d;
    end
  end

  assign data_read  = data_read_q;
  assign data_write = data_write_q;
  assign data_adr_o = data_adr_q;
  assign data_bus_o = data_bus_q;
  assign data_cpu_o = data_cpu_q;

endmodule

// File: tb/tb_dmem_alu.sv
// tb/tb_dmem_alu.sv - directed self-checking bench for dmem_alu

module tb_dmem_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemToReg;
  logic        ALU_source;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] reg1, reg2, immediate, data_bus_i;
  logic        data_good;
  logic [31:0] read_address, write_address, result;
  logic        branch, data_read, data_write;
  logic [31:0] data_adr_o, data_bus_o, data_cpu_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_v;

  dmem_alu dut (
    .clk(clk), .rst(rst), .MemToReg(MemToReg), .ALU_source(ALU_source),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .reg1(reg1), .reg2(reg2), .immediate(immediate),
    .data_bus_i(data_bus_i), .data_good(data_good),
    .read_address(read_address), .write_address(write_address),
    .result(result), .branch(branch),
    .data_read(data_read), .data_write(data_write),
    .data_adr_o(data_adr_o), .data_bus_o(data_bus_o), .data_cpu_o(data_cpu_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic src);
    opcode = op; funct3 = f3; funct7 = f7; reg1 = a; reg2 = b; immediate = b; ALU_source = src;
    #1;
  endtask

  initial begin
    rst = 1'b1; MemToReg = 1'b0; ALU_source = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    funct7 = 7'd0; reg1 = 32'd0; reg2 = 32'd0; immediate = 32'd0;
    data_bus_i = 32'd0; data_good = 1'b0;
    tick();
    check("rst_read", {31'd0, data_read}, 32'd0);
    check("rst_cpu", data_cpu_o, 32'd0);
    rst = 1'b0;

    // R-type ADD, no memory activity
    opcode = 7'b0110011; reg1 = 32'd1; reg2 = 32'd1;
    tick(); tick();
    check("add_result", result, 32'd2);
    check("add_raddr", read_address, 32'd0);
    check("add_waddr", write_address, 32'd0);
    check("add_read", {31'd0, data_read}, 32'd0);
    check("add_write", {31'd0, data_write}, 32'd0);
    check("add_adr", data_adr_o, 32'd0);
    check("add_bus", data_bus_o, 32'd0);
    check("add_cpu", data_cpu_o, 32'd0);

    // Load with data_good already high: two-edge access
    rst = 1'b1; #1; rst = 1'b0;
    opcode = 7'b0000011; funct3 = 3'b000; reg1 = 32'd1; reg2 = 32'd1; immediate = 32'd1;
    ALU_source = 1'b0; data_good = 1'b1; data_bus_i = 32'd1;
    tick();
    check("ld_strobe", {31'd0, data_read}, 32'd1);
    check("ld_adr", data_adr_o, 32'd2);
    tick();
    check("ld_raddr", read_address, 32'd2);
    check("ld_result", result, 32'd2);
    check("ld_waddr", write_address, 32'd0);
    check("ld_read_clr", {31'd0, data_read}, 32'd0);
    check("ld_write", {31'd0, data_write}, 32'd0);
    check("ld_adr_clr", data_adr_o, 32'd0);
    check("ld_bus", data_bus_o, 32'd0);
    check("ld_cpu", data_cpu_o, 32'd1);
    MemToReg = 1'b1; #1;
    check("ld_memtoreg", result, 32'd1);
    MemToReg = 1'b0;
    tick(); tick();
    check("ld_done_hold", {31'd0, data_read}, 32'd0);
    opcode = 7'b0110011; data_good = 1'b0;
    tick();

    // Store with a wait state and an opcode change mid-transaction
    opcode = 7'b0100011; funct3 = 3'b010; reg1 = 32'h100; immediate = 32'd4;
    ALU_source = 1'b1; reg2 = 32'hDEADBEEF; #1;
    check("st_waddr", write_address, 32'h104);
    check("st_raddr", read_address, 32'd0);
    tick();
    check("st_strobe", {31'd0, data_write}, 32'd1);
    check("st_adr", data_adr_o, 32'h104);
    check("st_bus", data_bus_o, 32'hDEADBEEF);
    opcode = 7'b0110011;
    tick();
    check("st_no_abort", {31'd0, data_write}, 32'd1);
    check("st_hold_adr", data_adr_o, 32'h104);
    opcode = 7'b0100011; data_good = 1'b1;
    tick();
    check("st_clr", {31'd0, data_write}, 32'd0);
    check("st_adr_clr", data_adr_o, 32'd0);
    check("st_bus_clr", data_bus_o, 32'd0);
    data_good = 1'b0;
    tick(); tick();
    check("st_one_txn", {31'd0, data_write}, 32'd0);
    check("st_one_adr", data_adr_o, 32'd0);

    // Branches
    set_alu(7'b1100011, 3'b000, 7'd0, 32'd5, 32'd5, 1'b0);
    check("beq_t", {31'd0, branch}, 32'd1);
    check("br_alu0", result, 32'd0);
    set_alu(7'b1100011, 3'b000, 7'd0, 32'd5, 32'd6, 1'b0);
    check("beq_nt", {31'd0, branch}, 32'd0);
    set_alu(7'b1100011, 3'b001, 7'd0, 32'd5, 32'd6, 1'b0);
    check("bne_t", {31'd0, branch}, 32'd1);
    set_alu(7'b1100011, 3'b100, 7'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("blt_t", {31'd0, branch}, 32'd1);
    set_alu(7'b1100011, 3'b101, 7'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("bge_nt", {31'd0, branch}, 32'd0);
    set_alu(7'b1100011, 3'b110, 7'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("bltu_nt", {31'd0, branch}, 32'd0);
    set_alu(7'b1100011, 3'b111, 7'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    check("bgeu_t", {31'd0, branch}, 32'd1);
    set_alu(7'b1100011, 3'b010, 7'd0, 32'd5, 32'd5, 1'b0);
    check("br_f3_010", {31'd0, branch}, 32'd0);
    set_alu(7'b0110011, 3'b000, 7'd0, 32'd5, 32'd5, 1'b0);
    check("br_non_br", {31'd0, branch}, 32'd0);

    // ALU operations
    set_alu(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 1'b0);
    check("sub", result, 32'hFFFFFFFE);
    set_alu(7'b0010011, 3'b000, 7'b0100000, 32'd5, 32'd7, 1'b1);
    check("addi_not_sub", result, 32'd12);
    set_alu(7'b0110011, 3'b001, 7'd0, 32'd1, 32'h24, 1'b0);
    check("sll", result, 32'h10);
    set_alu(7'b0110011, 3'b010, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    check("slt", result, 32'd1);
    set_alu(7'b0110011, 3'b011, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    check("sltu", result, 32'd0);
    set_alu(7'b0110011, 3'b100, 7'd0, 32'hF0F0, 32'hFF00, 1'b0);
    check("xor", result, 32'h0FF0);
    set_alu(7'b0110011, 3'b101, 7'd0, 32'h80000000, 32'd4, 1'b0);
    check("srl", result, 32'h08000000);
    set_alu(7'b0010011, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 1'b1);
    check("srai", result, 32'hF8000000);
    set_alu(7'b0110011, 3'b110, 7'd0, 32'hF0F0, 32'h0F0F, 1'b0);
    check("or", result, 32'hFFFF);
    set_alu(7'b0110011, 3'b111, 7'd0, 32'hF0F0, 32'hFF00, 1'b0);
    check("and", result, 32'hF000);
    set_alu(7'b0110111, 3'b000, 7'd0, 32'd5, 32'd7, 1'b0);
    check("other_op", result, 32'd0);

    // Asynchronous reset in the middle of a read
    opcode = 7'b0110011; tick();
    opcode = 7'b0000011; funct3 = 3'b000; reg1 = 32'h200; reg2 = 32'd0; ALU_source = 1'b0;
    data_good = 1'b0;
    tick();
    check("rd_strobe", {31'd0, data_read}, 32'd1);
    check("rd_adr", data_adr_o, 32'h200);
    #2 rst = 1'b1; #1;
    check("arst_read", {31'd0, data_read}, 32'd0);
    check("arst_adr", data_adr_o, 32'd0);
    check("arst_cpu", data_cpu_o, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("arst_idle_reissue", {31'd0, data_read}, 32'd1);

    // Load formatting
    data_good = 1'b1; data_bus_i = 32'h000000F0;
    tick();
`ifdef DMEM_LOAD_EXTEND_EN
    exp_v = 32'hFFFFFFF0;
`else
    exp_v = 32'h000000F0;
`endif
    check("lb", data_cpu_o, exp_v);
    opcode = 7'b0110011; data_good = 1'b0; tick();
    opcode = 7'b0000011; funct3 = 3'b100; data_good = 1'b1;
    tick(); tick();
    check("lbu", data_cpu_o, 32'h000000F0);
    opcode = 7'b0110011; data_good = 1'b0; tick();
    opcode = 7'b0000011; funct3 = 3'b001; data_good = 1'b1; data_bus_i = 32'h12348001;
    tick(); tick();
`ifdef DMEM_LOAD_EXTEND_EN
    exp_v = 32'hFFFF8001;
`else
    exp_v = 32'h12348001;
`endif
    check("lh", data_cpu_o, exp_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
